// File: rtl/mac_seq_pkg.sv
// Shared types and constant helpers for the layer-sequenced MAC/ReLU datapath.
package mac_seq_pkg;

  localparam int MAX_BITS = 64;
  localparam int DIMS_MAX = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } seq_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) r++;
    return r;
  endfunction

  // Field i of a packed dimension list, each field dim_w bits wide.
  function automatic int unsigned dim_field(input logic [DIMS_MAX-1:0] dims,
                                            input int dim_w, input int i);
    logic [DIMS_MAX-1:0] sh;
    sh = dims >> (dim_w * i);
    return 32'(sh & ((DIMS_MAX'(1'b1) << dim_w) - DIMS_MAX'(1'b1)));
  endfunction

  function automatic logic signed [MAX_BITS-1:0] saturate(input logic signed [MAX_BITS-1:0] v,
                                                          input int w);
    logic signed [MAX_BITS-1:0] hi;
    logic signed [MAX_BITS-1:0] lo;
    hi = (64'sd1 <<< (w - 32'sd1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 32'sd1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/mac_acc.sv
// Signed W x W multiply feeding a wide accumulator; sum is the combinational acc + product.
module mac_acc
  import mac_seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int ACC_W = 2 * W + 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     x,
  output logic signed [ACC_W-1:0] sum
);

  localparam int PW = 2 * W;

  logic signed [PW-1:0]    prod_s;
  logic signed [ACC_W-1:0] acc_r;

  assign prod_s = PW'(a) * PW'(x);
  assign sum    = acc_r + {{(ACC_W - PW){prod_s[PW-1]}}, prod_s};

  // Clear wins over accumulate so a finished dot product restarts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc_r <= '0;
    else if (clr) acc_r <= '0;
    else if (en)  acc_r <= sum;
  end

endmodule

// File: rtl/mxm_relu_seq.sv
// Multi-layer matrix-multiply sequencer: K-beat dot products, width reduction and per-layer ReLU.
module mxm_relu_seq
  import mac_seq_pkg::*;
#(
  parameter int                              W          = 8,
  parameter int                              NUM_LAYERS = 2,
  parameter int                              DIM_W      = 8,
  parameter logic [DIM_W*(NUM_LAYERS+2)-1:0] DIMS       = {8'd10, 8'd8, 8'd6, 8'd4},
  parameter int                              ACC_W      = 2 * W + 8,
  parameter logic [NUM_LAYERS-1:0]           RELU_MASK  = {NUM_LAYERS{1'b1}},
  parameter bit                              SAT        = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic signed [W-1:0]           a,
  input  logic signed [W-1:0]           x,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic signed [W-1:0]           y,
  output logic                          out_valid,
  output logic [clog2(NUM_LAYERS):0]    layer_idx,
  output logic                          last_out,
  output logic                          busy,
  output logic                          done
);

  localparam int LW = clog2(NUM_LAYERS) + 1;
  localparam int MW = 2 * DIM_W;
  localparam logic [DIMS_MAX-1:0] DIMS_EXT = DIMS_MAX'(DIMS);

  seq_state_e state_r, state_s;
  logic [DIM_W-1:0]        k_r, k_lim_s;
  logic [MW-1:0]           m_r, m_lim_s;
  logic [LW-1:0]           layer_r, layer_idx_r;
  logic                    relu_s, final_layer_s;
  logic                    beat_s, dot_done_s, layer_done_s, launch_s;
  logic signed [ACC_W-1:0] sum_s;
  logic signed [W-1:0]     red_s, act_s, y_r;
  logic                    out_valid_r, last_out_r, done_r;

  assign launch_s     = (state_r == IDLE) && start;
  assign beat_s       = in_valid && (state_r == RUN);
  assign dot_done_s   = (k_r == k_lim_s);
  assign layer_done_s = dot_done_s && (m_r == m_lim_s);

  mac_acc #(.W(W), .ACC_W(ACC_W)) u_mac (
    .clk (clk),
    .rst (rst),
    .en  (beat_s),
    .clr (launch_s || (beat_s && dot_done_s)),
    .a   (a),
    .x   (x),
    .sum (sum_s)
  );

  // Per-layer dot length (K-1), output count (OUTS-1) and activation select.
  always_comb begin
    k_lim_s       = '0;
    m_lim_s       = '0;
    relu_s        = 1'b0;
    final_layer_s = (layer_r == LW'(NUM_LAYERS - 1));
    for (int l = 0; l < NUM_LAYERS; l++) begin
      k_lim_s = (layer_r == LW'(l)) ? DIM_W'(dim_field(DIMS_EXT, DIM_W, l + 1) - 32'd1) : k_lim_s;
      m_lim_s = (layer_r == LW'(l)) ? MW'(dim_field(DIMS_EXT, DIM_W, l) *
                                          dim_field(DIMS_EXT, DIM_W, l + 2) - 32'd1) : m_lim_s;
      relu_s  = (layer_r == LW'(l)) ? RELU_MASK[l] : relu_s;
    end
  end

  // Width-reduce the finished sum, then apply the layer's ReLU.
  always_comb begin
    if (SAT) red_s = W'(saturate(MAX_BITS'(sum_s), W));
    else     red_s = sum_s[W-1:0];
    if (relu_s && red_s[W-1]) act_s = '0;
    else                      act_s = red_s;
  end

  // Next state: the final beat of the final layer drains through FLUSH.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    state_s = start ? RUN : IDLE;
      RUN:     state_s = (beat_s && layer_done_s && final_layer_s) ? FLUSH : RUN;
      FLUSH:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and beat/output/layer counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      k_r     <= '0;
      m_r     <= '0;
      layer_r <= '0;
    end else begin
      state_r <= state_s;
      if (launch_s) begin
        k_r     <= '0;
        m_r     <= '0;
        layer_r <= '0;
      end else if (beat_s) begin
        if (!dot_done_s) begin
          k_r <= k_r + DIM_W'(1'b1);
        end else if (!layer_done_s) begin
          k_r <= '0;
          m_r <= m_r + MW'(1'b1);
        end else begin
          k_r     <= '0;
          m_r     <= '0;
          layer_r <= layer_r + LW'(1'b1);
        end
      end
    end
  end

  // Output registers; y and layer_idx hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_r         <= '0;
      layer_idx_r <= '0;
      out_valid_r <= 1'b0;
      last_out_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      out_valid_r <= beat_s && dot_done_s;
      last_out_r  <= beat_s && layer_done_s;
      done_r      <= beat_s && layer_done_s && final_layer_s;
      if (beat_s && dot_done_s) begin
        y_r         <= act_s;
        layer_idx_r <= layer_r;
      end
    end
  end

  assign in_ready  = (state_r == RUN);
  assign busy      = (state_r == RUN);
  assign y         = y_r;
  assign out_valid = out_valid_r;
  assign layer_idx = layer_idx_r;
  assign last_out  = last_out_r;
  assign done      = done_r;

endmodule

// File: tb/tb_mxm_relu_seq.sv
// Bench for mxm_relu_seq: default two-layer instance plus three one-layer SAT/ReLU variants.
`timescale 1ns/1ps
module tb_mxm_relu_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              start0, in_valid0, in_ready0, out_valid0, last_out0, busy0, done0;
  logic signed [7:0] a0, x0, y0;
  logic [1:0]        lidx0;

  logic              start1, in_valid1;
  logic signed [7:0] a1, x1;
  logic signed [7:0] ys [3];
  logic              ovs [3], lasts [3], dones [3], rdys [3], busys [3], lids [3];

  mxm_relu_seq u0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .x(x0), .in_valid(in_valid0),
    .in_ready(in_ready0), .y(y0), .out_valid(out_valid0), .layer_idx(lidx0),
    .last_out(last_out0), .busy(busy0), .done(done0));

  mxm_relu_seq #(.NUM_LAYERS(1), .DIMS({8'd2, 8'd3, 8'd2}), .RELU_MASK(1'b1), .SAT(1'b1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .x(x1), .in_valid(in_valid1),
    .in_ready(rdys[0]), .y(ys[0]), .out_valid(ovs[0]), .layer_idx(lids[0]),
    .last_out(lasts[0]), .busy(busys[0]), .done(dones[0]));

  mxm_relu_seq #(.NUM_LAYERS(1), .DIMS({8'd2, 8'd3, 8'd2}), .RELU_MASK(1'b0), .SAT(1'b1)) u2 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .x(x1), .in_valid(in_valid1),
    .in_ready(rdys[1]), .y(ys[1]), .out_valid(ovs[1]), .layer_idx(lids[1]),
    .last_out(lasts[1]), .busy(busys[1]), .done(dones[1]));

  mxm_relu_seq #(.NUM_LAYERS(1), .DIMS({8'd2, 8'd3, 8'd2}), .RELU_MASK(1'b0), .SAT(1'b0)) u3 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .x(x1), .in_valid(in_valid1),
    .in_ready(rdys[2]), .y(ys[2]), .out_valid(ovs[2]), .layer_idx(lids[2]),
    .last_out(lasts[2]), .busy(busys[2]), .done(dones[2]));

  int n_assert = 0;
  int n_fail   = 0;
  int nov0     = 0;
  int exp_y0   = 0;

  always @(negedge clk) if (out_valid0 === 1'b1) nov0++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: reduce a dot-product sum to 8 bits (clamp or wrap), then optional ReLU.
  function automatic int ref_y(input longint s, input bit sat, input bit relu);
    longint r;
    if (sat) r = (s > 127) ? 127 : ((s < -128) ? -128 : s);
    else begin
      r = s & 64'hFF;
      if (r > 127) r = r - 256;
    end
    if (relu && r < 0) r = 0;
    return int'(r);
  endfunction

  // mode 0: all ones, 1: full-range random, 2: small random. abort_at>0 resets after that beat.
  task automatic run_main(input int mode, input bit tog, input int abort_at);
    int fld [4] = '{4, 6, 8, 10};
    int nb, ov_base, outs, e, ka, kx;
    longint sum;
    nb = 0;
    ov_base = nov0;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("busy_after_start", busy0, 1);
    for (int l = 0; l < 2; l++) begin
      outs = fld[l] * fld[l + 2];
      for (int o = 0; o < outs; o++) begin
        sum = 0;
        for (int k = 0; k < fld[l + 1]; k++) begin
          if (tog) begin
            in_valid0 = 1'b0;
            a0 = 8'($urandom);
            x0 = 8'($urandom);
            step();
            chk("idle_no_out", out_valid0, 0);
          end
          case (mode)
            0:       begin ka = 1; kx = 1; end
            1:       begin ka = int'($urandom_range(0, 255)) - 128; kx = int'($urandom_range(0, 255)) - 128; end
            default: begin ka = int'($urandom_range(0, 6)) - 3; kx = int'($urandom_range(0, 6)) - 3; end
          endcase
          a0 = 8'(ka);
          x0 = 8'(kx);
          in_valid0 = 1'b1;
          chk("in_ready", in_ready0, 1);
          start0 = (nb == 100);
          step();
          start0 = 1'b0;
          in_valid0 = 1'b0;
          sum += longint'(ka * kx);
          nb++;
          if (nb == abort_at) begin
            rst = 1'b1;
            #2;
            chk("abort_out_valid", out_valid0, 0);
            chk("abort_busy", busy0, 0);
            chk("abort_in_ready", in_ready0, 0);
            chk("abort_y", y0, 0);
            chk("abort_layer_idx", lidx0, 0);
            chk("abort_last_out", last_out0, 0);
            chk("abort_done", done0, 0);
            step();
            rst = 1'b0;
            exp_y0 = 0;
            repeat (3) begin
              step();
              chk("abort_no_done", done0, 0);
            end
            return;
          end
          if (k == fld[l + 1] - 1) begin
            e = ref_y(sum, 1'b1, 1'b1);
            exp_y0 = e;
            chk("out_valid", out_valid0, 1);
            chk("y", y0, e);
            chk("layer_idx", lidx0, l);
            chk("last_out", last_out0, o == outs - 1);
            chk("done", done0, (l == 1) && (o == outs - 1));
          end else begin
            chk("no_out", out_valid0, 0);
            chk("y_hold", y0, exp_y0);
          end
        end
      end
    end
    chk("flush_in_ready", in_ready0, 0);
    in_valid0 = 1'b1;
    repeat (2) begin
      step();
      chk("post_busy", busy0, 0);
      chk("post_out_valid", out_valid0, 0);
      chk("post_done", done0, 0);
    end
    in_valid0 = 1'b0;
    chk("out_count", nov0 - ov_base, 92);
  endtask

  // Directed vectors on the one-layer variants (K=3, OUTS=4), checked against the reference.
  task automatic run_mini(input bit tog);
    int va [12] = '{3, -2, 1, -5, 0, 0, 127, 127, 127, -128, -128, -128};
    int vx [12] = '{4, 5, 1, 5, 0, 0, 127, 127, 127, 127, 127, 127};
    longint sum;
    int e;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    for (int d = 0; d < 4; d++) begin
      sum = 0;
      for (int k = 0; k < 3; k++) begin
        if (tog) begin
          in_valid1 = 1'b0;
          step();
          chk("mini_idle", ovs[0], 0);
        end
        a1 = 8'(va[d * 3 + k]);
        x1 = 8'(vx[d * 3 + k]);
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        sum += longint'(va[d * 3 + k] * vx[d * 3 + k]);
        if (k == 2) begin
          for (int i = 0; i < 3; i++) begin
            e = ref_y(sum, i != 2, i == 0);
            chk($sformatf("mini_ov%0d", i), ovs[i], 1);
            chk($sformatf("mini_y%0d_dot%0d", i, d), ys[i], e);
            chk($sformatf("mini_lidx%0d", i), lids[i], 0);
            chk($sformatf("mini_last%0d", i), lasts[i], d == 3);
            chk($sformatf("mini_done%0d", i), dones[i], d == 3);
          end
        end else begin
          chk("mini_no_out", ovs[0], 0);
        end
      end
    end
    step();
    chk("mini_idle_busy", busys[0], 0);
    chk("mini_idle_ready", rdys[2], 0);
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; in_valid0 = 1'b0; a0 = '0; x0 = '0;
    start1 = 1'b0; in_valid1 = 1'b0; a1 = '0; x1 = '0;
    #12;
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_y", y0, 0);
    chk("rst_layer_idx", lidx0, 0);
    chk("rst_last_out", last_out0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_mini_y", ys[1], 0);
    step();
    rst = 1'b0;

    in_valid0 = 1'b1;
    a0 = 8'sd5;
    x0 = 8'sd5;
    repeat (3) begin
      step();
      chk("idle_ignore_ov", out_valid0, 0);
      chk("idle_in_ready", in_ready0, 0);
    end
    in_valid0 = 1'b0;

    run_main(0, 1'b0, 0);
    run_main(1, 1'b1, 0);
    run_main(2, 1'b0, 250);
    run_main(1, 1'b0, 0);
    run_main(0, 1'b1, 0);
    run_mini(1'b0);
    run_mini(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mxm_relu_seq.md
Name: mxm_relu_seq

Overview:
- Parametrised multi-layer matrix-multiply sequencer with per-layer activation, for the MAC_TG garbled-circuit flow.
- Streams operand pairs serially. Each pair is multiply-accumulated into a wide signed accumulator. Every K-th pair, it emits one activated, width-reduced result.
- Successor to the fixed 2-layer MxM/ReLU block. Adds:
  - parametrised layer count and dimensions
  - per-layer ReLU enable
  - saturating output mode
  - start/ready/valid handshakes and a done indication

Parameters:
- W, 8: operand and output bit-width (signed two's complement).
- NUM_LAYERS, 2: number of layers processed per start.
- DIM_W, 8: bit-width of one dimension field.
- DIMS, {8'd10,8'd8,8'd6,8'd4}: packed (NUM_LAYERS+2) fields of DIM_W bits. Field i = DIMS[DIM_W*i +: DIM_W]. Each field is ≥1.
- ACC_W, 2*W+8: accumulator width. Must hold the sum of max-K full products.
- RELU_MASK, {NUM_LAYERS{1'b1}}: bit l=1 applies ReLU on layer l.
- SAT, 1: 1 = saturate to signed W range; 0 = keep low W bits (wrap).

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: begin a run; sampled only in IDLE.
- a, input, W: signed operand (garbler side).
- x, input, W: signed operand (evaluator side).
- in_valid, input, 1: a/x valid this cycle.
- in_ready, output, 1: block accepts a beat this cycle.
- y, output, W: activated result.
- out_valid, output, 1: one-cycle pulse, y valid.
- layer_idx, output, clog2(NUM_LAYERS)+1: layer of the current/last output.
- last_out, output, 1: with out_valid, marks the final output of a layer.
- busy, output, 1: high in RUN.
- done, output, 1: one-cycle pulse after the final output of the final layer.

Behaviour:
- Reset state: all outputs 0. FSM=IDLE. Counters k, m, layer = 0. Accumulator = 0. Reset mid-run aborts immediately with no done pulse.
- Per-layer values: K(l) = field l+1; OUTS(l) = field l × field l+2. Defaults give layer0 K=6, OUTS=32; layer1 K=8, OUTS=60.
- FSM states: IDLE, RUN, FLUSH.
  - IDLE→RUN on start. Clears counters and accumulator.
  - start in RUN or FLUSH is ignored.
- in_ready = (state==RUN). A beat is accepted when in_valid && in_ready.
- Accumulation: acc_next = acc + sext(a×x), signed full 2W product sign-extended to ACC_W. Cycles without a beat hold acc and all counters.
- Dot-product completion, on the accepted beat with k==K(l)-1:
  - Store sum = acc + product in the result register. Clear acc to 0 in the same cycle, so the next beat starts a fresh sum.
  - k→0, m→m+1.
- Output timing: out_valid is registered, asserting the cycle after the completing beat (latency 1). y = act(reduce(sum)).
  - reduce: SAT=1 clamps to [-2^(W-1), 2^(W-1)-1]. SAT=0 takes sum[W-1:0].
  - act: if RELU_MASK[l] and the reduced value is negative, y=0; otherwise y = reduced value.
  - y holds between pulses.
- Layer advance: completing beat with m==OUTS(l)-1 sets last_out with that output, m→0, layer→layer+1.
  - If it was the last layer, enter FLUSH (in_ready=0). FLUSH→IDLE next cycle, with done=1 that cycle, coincident with the final out_valid.
- layer_idx updates with each out_valid and equals the layer that produced y.
- Back-to-back beats: the block sustains one accepted beat per cycle with no bubbles across output or layer boundaries (except the final FLUSH).
- No output backpressure; the consumer must take every out_valid pulse.
- K=1: every accepted beat produces an output.

Decomposition:
- Package mac_seq_pkg:
  - FSM state enum (IDLE, RUN, FLUSH)
  - function dim_field(DIMS, i)
  - clog2 helper
  - signed saturate(sum, W) function
- Sub-module mac_acc: signed W×W multiply plus ACC_W accumulate, with clear and enable inputs, returning the combinational sum. The top holds the FSM, counters, activation and output registers.

Test Plan:
- Defaults, all beats a=1, x=1 continuous: 32 out_valid with y=6 on layer0, then 60 with y=8 on layer1. last_out on the 32nd and 92nd outputs. done coincident with the 92nd out_valid. Exactly 32×6+60×8=672 beats accepted.
- NUM_LAYERS=1, DIMS={2,3,2}, SAT=1, RELU on: beats (a,x)=(3,4),(−2,5),(1,1) → sum=3 → y=3. Next dot (−5,5),(0,0),(0,0) → sum=−25 → y=0.
- Same config, SAT=1, RELU off: (127,127)×3 → y=127 (clamped). (−128,127)×3 → y=−128. With SAT=0, (127,127)×3 → sum 48387 → y=sum[7:0]=3.
- in_valid toggled 1/0 every cycle: outputs identical to the continuous case. Result appears 1 cycle after each completing beat. acc unchanged in idle cycles.
- Assert rst for one cycle mid-layer1: all outputs 0 immediately, no done. New start restarts from layer0 with acc=0.
- start pulsed while busy, and in_valid while IDLE: both ignored. Output count and beat count are unchanged.
